router_pkt_ctrl: RTL

ROUTER_PKT_CTRL -- requirements
Module: router_pkt_ctrl

---
 rtl/router_pkt_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/router_pkt_ctrl.sv
// router_pkt_ctrl: packet router control path.
// Parses a header byte (length L in [7:2], destination A in [1:0]),
// steers header, payload and trailing parity byte into one of three output
// FIFOs, checks the running XOR parity and discards packets addressed to
// the invalid port 3.
// Optional feature macro: ROUTER_TIMEOUT_EN enables per-FIFO read-timeout
// counters that pulse soft_reset and abort an in-flight packet to DROP.
module router_pkt_ctrl #(
    parameter int TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [2:0] write_enb,
    output logic       lfd_state,
    output logic [7:0] dout,
    output logic       busy,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset,
    output logic       err,
    output logic       parity_done
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_EMPTY  = 3'd1,
        S_LFD         = 3'd2,
        S_LOAD_HDR    = 3'd3,
        S_LOAD_DATA   = 3'd4,
        S_LOAD_PARITY = 3'd5,
        S_CHECK       = 3'd6,
        S_DROP        = 3'd7
    } state_t;

    // Running parity accumulation over the packet bytes.
    function automatic logic [7:0] parity_step(input logic [7:0] acc, input logic [7:0] din);
        parity_step = acc ^ din;
    endfunction

    // Select one FIFO flag by address; address 3 has no FIFO and reads as 0.
    function automatic logic sel_flag(input logic [2:0] vec, input logic [1:0] idx);
        case (idx)
            2'd0:    sel_flag = vec[0];
            2'd1:    sel_flag = vec[1];
            2'd2:    sel_flag = vec[2];
            default: sel_flag = 1'b0;
        endcase
    endfunction

    // One-hot FIFO select for a destination address.
    function automatic logic [2:0] addr_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    addr_onehot = 3'b001;
            2'd1:    addr_onehot = 3'b010;
            2'd2:    addr_onehot = 3'b100;
            default: addr_onehot = 3'b000;
        endcase
    endfunction

    state_t      state_r;
    logic [7:0]  hdr_r;
    logic [1:0]  addr_r;
    logic [5:0]  len_r;
    logic [5:0]  cnt_r;
    logic [7:0]  parity_r;
    logic [7:0]  rx_parity_r;
    logic [6:0]  drop_cnt_r;

    logic        full_a_s;
    logic        empty_a_s;
    logic        sr_hit_s;
    logic        busy_s;
    logic        accept_s;
    logic [2:0]  soft_reset_s;

    assign vld_out   = ~fifo_empty;
    assign full_a_s  = sel_flag(fifo_full, addr_r);
    assign empty_a_s = sel_flag(fifo_empty, addr_r);

`ifdef ROUTER_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [TW-1:0] tcnt_r [0:2];
    logic [2:0]    soft_reset_r;

    // Per-FIFO unread-cycle counters; a full count pulses soft_reset for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                tcnt_r[i] <= '0;
            end
            soft_reset_r <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (vld_out[i] && !read_enb[i]) begin
                    if (tcnt_r[i] == TW'(TIMEOUT - 1)) begin
                        tcnt_r[i]       <= '0;
                        soft_reset_r[i] <= 1'b1;
                    end else begin
                        tcnt_r[i]       <= tcnt_r[i] + TW'(1);
                        soft_reset_r[i] <= 1'b0;
                    end
                end else begin
                    tcnt_r[i]       <= '0;
                    soft_reset_r[i] <= 1'b0;
                end
            end
        end
    end

    assign soft_reset_s = soft_reset_r;
`else
    logic unused_read_enb_s;

    assign unused_read_enb_s = ^read_enb;
    assign soft_reset_s      = 3'b000;
`endif

    assign soft_reset = soft_reset_s;

    // Abort condition: the destination FIFO is soft-reset while this packet owns it.
    always_comb begin
        sr_hit_s = 1'b0;
        case (state_r)
            S_WAIT_EMPTY, S_LFD, S_LOAD_HDR, S_LOAD_DATA, S_LOAD_PARITY:
                sr_hit_s = sel_flag(soft_reset_s, addr_r);
            default:
                sr_hit_s = 1'b0;
        endcase
    end

    // Source handshake: busy per state; an abort cycle holds the source off too.
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            S_IDLE:                     busy_s = 1'b0;
            S_WAIT_EMPTY:               busy_s = 1'b1;
            S_LFD:                      busy_s = 1'b1;
            S_LOAD_HDR:                 busy_s = 1'b1;
            S_LOAD_DATA, S_LOAD_PARITY: busy_s = full_a_s | sr_hit_s;
            S_CHECK:                    busy_s = 1'b1;
            S_DROP:                     busy_s = 1'b0;
            default:                    busy_s = 1'b0;
        endcase
    end

    assign busy     = busy_s;
    assign accept_s = pkt_valid & ~busy_s;

    // Output decode from current state, FIFO flags and accepted source byte.
    always_comb begin
        write_enb   = 3'b000;
        dout        = 8'h00;
        lfd_state   = 1'b0;
        err         = 1'b0;
        parity_done = 1'b0;
        case (state_r)
            S_LFD: begin
                lfd_state = 1'b1;
            end
            S_LOAD_HDR: begin
                dout = hdr_r;
                if (!full_a_s && !sr_hit_s) begin
                    write_enb = addr_onehot(addr_r);
                end else begin
                    write_enb = 3'b000;
                end
            end
            S_LOAD_DATA, S_LOAD_PARITY: begin
                if (accept_s) begin
                    write_enb = addr_onehot(addr_r);
                    dout      = data_in;
                end else begin
                    write_enb = 3'b000;
                    dout      = 8'h00;
                end
            end
            S_CHECK: begin
                parity_done = 1'b1;
                err         = (rx_parity_r != parity_r);
            end
            S_DROP: begin
                if (accept_s && (drop_cnt_r == 7'd1) && (addr_r == 2'd3)) begin
                    err = 1'b1;
                end else begin
                    err = 1'b0;
                end
            end
            default: begin
                write_enb = 3'b000;
            end
        endcase
    end

    // Packet FSM with header, counters and parity registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= S_IDLE;
            hdr_r       <= 8'h00;
            addr_r      <= 2'd0;
            len_r       <= 6'd0;
            cnt_r       <= 6'd0;
            parity_r    <= 8'h00;
            rx_parity_r <= 8'h00;
            drop_cnt_r  <= 7'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        hdr_r    <= data_in;
                        addr_r   <= data_in[1:0];
                        len_r    <= data_in[7:2];
                        cnt_r    <= 6'd0;
                        parity_r <= data_in;
                        if (data_in[1:0] == 2'd3) begin
                            drop_cnt_r <= {1'b0, data_in[7:2]} + 7'd1;
                            state_r    <= S_DROP;
                        end else if (sel_flag(fifo_empty, data_in[1:0])) begin
                            state_r <= S_LFD;
                        end else begin
                            state_r <= S_WAIT_EMPTY;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WAIT_EMPTY: begin
                    if (sr_hit_s) begin
                        drop_cnt_r <= {1'b0, len_r} + 7'd1;
                        state_r    <= S_DROP;
                    end else if (empty_a_s) begin
                        state_r <= S_LFD;
                    end else begin
                        state_r <= S_WAIT_EMPTY;
                    end
                end
                S_LFD: begin
                    if (sr_hit_s) begin
                        drop_cnt_r <= {1'b0, len_r} + 7'd1;
                        state_r    <= S_DROP;
                    end else begin
                        state_r <= S_LOAD_HDR;
                    end
                end
                S_LOAD_HDR: begin
                    if (sr_hit_s) begin
                        drop_cnt_r <= {1'b0, len_r} + 7'd1;
                        state_r    <= S_DROP;
                    end else if (full_a_s) begin
                        state_r <= S_LOAD_HDR;
                    end else if (len_r != 6'd0) begin
                        state_r <= S_LOAD_DATA;
                    end else begin
                        state_r <= S_LOAD_PARITY;
                    end
                end
                S_LOAD_DATA: begin
                    if (sr_hit_s) begin
                        drop_cnt_r <= {1'b0, len_r} - {1'b0, cnt_r} + 7'd1;
                        state_r    <= S_DROP;
                    end else if (accept_s) begin
                        parity_r <= parity_step(parity_r, data_in);
                        cnt_r    <= cnt_r + 6'd1;
                        if ((cnt_r + 6'd1) == len_r) begin
                            state_r <= S_LOAD_PARITY;
                        end else begin
                            state_r <= S_LOAD_DATA;
                        end
                    end else begin
                        state_r <= S_LOAD_DATA;
                    end
                end
                S_LOAD_PARITY: begin
                    if (sr_hit_s) begin
                        drop_cnt_r <= 7'd1;
                        state_r    <= S_DROP;
                    end else if (accept_s) begin
                        rx_parity_r <= data_in;
                        state_r     <= S_CHECK;
                    end else begin
                        state_r <= S_LOAD_PARITY;
                    end
                end
                S_CHECK: begin
                    state_r <= S_IDLE;
                end
                S_DROP: begin
                    if (drop_cnt_r == 7'd0) begin
                        state_r <= S_IDLE;
                    end else if (accept_s) begin
                        drop_cnt_r <= drop_cnt_r - 7'd1;
                        if (drop_cnt_r == 7'd1) begin
                            state_r <= S_IDLE;
                        end else begin
                            state_r <= S_DROP;
                        end
                    end else begin
                        state_r <= S_DROP;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
